// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for lsu_ctrl: funct3/mask/state encodings, request record and
// the decode helpers used at request acceptance.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

  // Unsigned widths exist only for loads.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == MASK_H) && lsb[0]) || ((size == MASK_W) && (lsb != 2'b00));
  endfunction

  function automatic logic [31:0] align_addr(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      MASK_H:  return {addr[31:1], 1'b0};
      MASK_W:  return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_ext.sv
// Combinational sign/zero extender for load data already lane-extracted by the responder.
// Selection follows the RISC-V funct3 of the registered load.
module lsu_load_ext
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (funct3)
      F3_B:    ext = {{24{data[7]}}, data[7:0]};
      F3_BU:   ext = {24'b0, data[7:0]};
      F3_H:    ext = {{16{data[15]}}, data[15:0]};
      F3_HU:   ext = {16'b0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer onto a synchronous-read DRAM bus; store 3 cycles,
// load 3+RD_LATENCY, no response backpressure. LSU_MISALIGN_TRAP_EN traps misaligned ops.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic [31:0] perip_addr,
  output logic [31:0] perip_wdata,
  output logic [1:0]  perip_mask,
  output logic        dram_wen,
  input  logic [31:0] perip_rdata
);

  logic [1:0]  state;
  lsu_req_t    req_q;
  logic [2:0]  cnt;
  logic [31:0] data_q;
  logic        err_q;
  logic        accept;
  logic        legal;
  logic        bus_active;
  logic [31:0] ext_data;

  assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis   = misaligned(req_funct3[1:0], req_addr[1:0]);
  assign legal = funct3_legal(req_is_store, req_funct3) && !mis;
`else
  assign legal = funct3_legal(req_is_store, req_funct3);
`endif

  lsu_load_ext u_ext (
    .funct3 (req_q.funct3),
    .data   (perip_rdata),
    .ext    (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_q  <= '0;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q.is_store <= req_is_store;
            req_q.funct3   <= req_funct3;
            req_q.addr     <= align_addr(req_funct3[1:0], req_addr);
            req_q.wdata    <= req_wdata;
            req_q.rd       <= req_rd;
            data_q         <= '0;
            err_q          <= !legal;
            state          <= legal ? ST_ACCESS : ST_DONE;
          end
        end
        ST_ACCESS: begin
          if (req_q.is_store) begin
            state <= ST_DONE;
          end else begin
            cnt   <= 3'(RD_LATENCY - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            data_q <= ext_data;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Everything bus-facing is decoded from the state register so reset drops it at once.
  assign bus_active  = (state == ST_ACCESS) || (state == ST_WAIT);
  assign req_ready   = (state == ST_IDLE);
  assign dram_wen    = (state == ST_ACCESS) && req_q.is_store;
  assign perip_addr  = bus_active ? req_q.addr : 32'd0;
  assign perip_wdata = bus_active ? req_q.wdata : 32'd0;
  assign perip_mask  = bus_active ? req_q.funct3[1:0] : 2'b00;

  assign rsp_valid = (state == ST_DONE);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? data_q : 32'd0;
  assign rsp_rd    = (rsp_valid && !req_q.is_store) ? req_q.rd : 5'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl against a byte-lane DRAM model with one-cycle read latency.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_err, dram_wen;
  logic [31:0] rsp_rdata, perip_addr, perip_wdata, perip_rdata;
  logic [4:0]  rsp_rd;
  logic [1:0]  perip_mask;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .perip_addr(perip_addr), .perip_wdata(perip_wdata), .perip_mask(perip_mask),
    .dram_wen(dram_wen), .perip_rdata(perip_rdata)
  );

  always #5 clk = ~clk;

  // DRAM responder: lane-shifted writes, registered lane-extracted zero-extended reads.
  logic [31:0] mem [256];
  logic [31:0] rd_word, rd_shift;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    perip_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (dram_wen) begin
      case (perip_mask)
        2'b00:   mem[perip_addr[9:2]][{perip_addr[1:0], 3'b000} +: 8] <= perip_wdata[7:0];
        2'b01:   mem[perip_addr[9:2]][{perip_addr[1], 4'b0000} +: 16] <= perip_wdata[15:0];
        default: mem[perip_addr[9:2]] <= perip_wdata;
      endcase
    end
    rd_word  = mem[perip_addr[9:2]];
    rd_shift = rd_word >> {perip_addr[1:0], 3'b000};
    case (perip_mask)
      2'b00:   perip_rdata <= {24'd0, rd_shift[7:0]};
      2'b01:   perip_rdata <= {16'd0, rd_shift[15:0]};
      default: perip_rdata <= rd_word;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] res_rdata, res_addr;
  logic [4:0]  res_rd;
  logic [1:0]  res_mask;
  logic        res_err, res_done;
  int          res_lat, res_wen, res_bus;

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    res_done = 1'b0; res_lat = 0; res_wen = 0; res_bus = 0;
    res_addr = 32'd0; res_mask = 2'b11; res_rdata = 32'hx; res_err = 1'bx; res_rd = 5'hx;
    for (int n = 1; n <= 20 && !res_done; n++) begin
      @(negedge clk);
      if (dram_wen) res_wen++;
      if (perip_addr != 32'd0 || perip_mask != 2'b00 || dram_wen) begin
        if (res_bus == 0) begin
          res_addr = perip_addr;
          res_mask = perip_mask;
        end
        res_bus++;
      end
      if (rsp_valid) begin
        res_done = 1'b1; res_lat = n;
        res_rdata = rsp_rdata; res_err = rsp_err; res_rd = rsp_rd;
      end
    end
    check("rsp_seen", 32'(res_done), 32'd1);
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    #3;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_wen", 32'(dram_wen), 32'd0);
    check("rst_paddr", perip_addr, 32'd0);
    check("rst_pmask", 32'(perip_mask), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
    check("sw_lat", res_lat, 2);
    check("sw_wen", res_wen, 1);
    check("sw_err", 32'(res_err), 32'd0);
    check("sw_rdata", res_rdata, 32'd0);
    run_op(1'b0, 3'b010, 32'h100, 32'd0, 5'd7);
    check("lw_data", res_rdata, 32'hDEADBEEF);
    check("lw_lat", res_lat, 3);
    check("lw_wen", res_wen, 0);
    check("lw_rd", 32'(res_rd), 32'd7);

    run_op(1'b1, 3'b000, 32'h103, 32'h00000080, 5'd0);
    check("sb_addr", res_addr, 32'h103);
    check("sb_mask", 32'(res_mask), 32'd0);
    run_op(1'b0, 3'b000, 32'h103, 32'd0, 5'd3);
    check("lb_data", res_rdata, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h103, 32'd0, 5'd3);
    check("lbu_data", res_rdata, 32'h00000080);

    run_op(1'b1, 3'b001, 32'h102, 32'h00008001, 5'd0);
    check("sh_mask", 32'(res_mask), 32'd1);
    run_op(1'b0, 3'b001, 32'h102, 32'd0, 5'd4);
    check("lh_data", res_rdata, 32'hFFFF8001);
    run_op(1'b0, 3'b101, 32'h102, 32'd0, 5'd4);
    check("lhu_data", res_rdata, 32'h00008001);

    run_op(1'b0, 3'b010, 32'h100, 32'd0, 5'd5);
    check("lw_merged", res_rdata, 32'h8001BEEF);
    run_op(1'b0, 3'b010, 32'h101, 32'd0, 5'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err", 32'(res_err), 32'd1);
    check("lw_mis_rdata", res_rdata, 32'd0);
    check("lw_mis_bus", res_bus, 0);
    check("lw_mis_lat", res_lat, 1);
`else
    check("lw_mis_err", 32'(res_err), 32'd0);
    check("lw_mis_addr", res_addr, 32'h100);
    check("lw_mis_data", res_rdata, 32'h8001BEEF);
`endif

    run_op(1'b0, 3'b011, 32'h100, 32'd0, 5'd6);
    check("f3_011_err", 32'(res_err), 32'd1);
    check("f3_011_lat", res_lat, 1);
    check("f3_011_bus", res_bus, 0);
    check("f3_011_rdata", res_rdata, 32'd0);
    run_op(1'b1, 3'b100, 32'h100, 32'h12345678, 5'd0);
    check("sbu_err", 32'(res_err), 32'd1);
    check("sbu_wen", res_wen, 0);

    // Reset during a store's ACCESS cycle must abort it without touching memory.
    run_op(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 5'd0);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h11111111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_wen_pre", 32'(dram_wen), 32'd1);
    rst = 1'b1;
    #1 check("rst_mid_wen_drop", 32'(dram_wen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("rst_mid_no_rsp", 32'(seen_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    run_op(1'b0, 3'b010, 32'h200, 32'd0, 5'd9);
    check("rst_mid_mem", res_rdata, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
